// File: rtl/img_mem_arbiter.sv
// img_mem_arbiter
// Round-robin owner arbitration for the single-port 36x3 image RAM shared by
// the pixel scanner (0), row mapper (1), column mapper (2) and star cleaner (3).
// An owner keeps the RAM until it drops req. It is also forced out after
// MAX_BURST accepted accesses when someone else is waiting. Read data is
// returned with a per-requester valid strobe one cycle after the access.
//
// Ports
//   clk, resetn      clock, synchronous active-low reset
//   req[3:0]         ownership requests
//   acc[3:0]         access strobes, honoured only for the granted requester
//   wr[3:0]          write qualifier per requester (1 write, 0 read)
//   addr, wdata      packed per-requester address / write data
//   gnt, owner, busy registered one-hot grant, owner index, any-grant flag
//   rvalid, rdata    read return strobe per requester, shared read data
//   acc_err          sticky: an access strobe arrived without its grant
//   mem_addr, mem_data, mem_wren, mem_q   RAM port
module img_mem_arbiter #(
  parameter int ADDR_SZ   = 6,
  parameter int COL_SZ    = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [3:0]             req,
  input  logic [3:0]             acc,
  input  logic [3:0]             wr,
  input  logic [4*ADDR_SZ-1:0]   addr,
  input  logic [4*COL_SZ-1:0]    wdata,
  output logic [3:0]             gnt,
  output logic [1:0]             owner,
  output logic                   busy,
  output logic [3:0]             rvalid,
  output logic [COL_SZ-1:0]      rdata,
  output logic                   acc_err,
  output logic [ADDR_SZ-1:0]     mem_addr,
  output logic [COL_SZ-1:0]      mem_data,
  output logic                   mem_wren,
  input  logic [COL_SZ-1:0]      mem_q
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state;
  logic [1:0]         last;
  logic [CNT_W-1:0]   burstCnt;
  logic [CNT_W-1:0]   burstCntNext;
  logic [3:0]         rvld_p1;
  logic [ADDR_SZ-1:0] addrArr [4];
  logic [COL_SZ-1:0]  dataArr [4];
  logic               accept;
  logic               otherReq;
  logic               relOwn;
  logic [1:0]         winner;

  // Round-robin search starting just above the previous owner. Walking the
  // offsets from far to near lets the nearest requesting index win.
  function automatic logic [1:0] pickWinner(input logic [3:0] r,
                                            input logic [1:0] prev);
    logic [1:0] idx;
    pickWinner = prev + 2'd1;
    for (int i = 4; i >= 1; i--) begin
      idx = prev + 2'(i);
      if (r[idx]) pickWinner = idx;
    end
  endfunction

  function automatic logic [3:0] oneHot(input logic [1:0] idx);
    oneHot = 4'b0001 << idx;
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      addrArr[i] = addr[i*ADDR_SZ +: ADDR_SZ];
      dataArr[i] = wdata[i*COL_SZ +: COL_SZ];
    end
  end

  // gnt is only ever set at bit owner, so this is the whole accept rule;
  // strobes from anyone else never reach the RAM.
  assign accept   = gnt[owner] & acc[owner];
  assign mem_addr = accept ? addrArr[owner] : '0;
  assign mem_data = accept ? dataArr[owner] : '0;
  assign mem_wren = accept & wr[owner];

  assign burstCntNext = (accept && burstCnt != CNT_W'(MAX_BURST)) ?
                        burstCnt + CNT_W'(1) : burstCnt;
  assign otherReq     = |(req & ~oneHot(owner));
  assign relOwn       = !req[owner] ||
                        (burstCntNext >= CNT_W'(MAX_BURST) && otherReq);
  assign winner       = pickWinner(req, last);

  assign busy   = |gnt;
  assign rvalid = rvld_p1;
  assign rdata  = mem_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      last     <= 2'd3;
      burstCnt <= '0;
      rvld_p1  <= '0;
      acc_err  <= 1'b0;
    end else begin
      // p0 -> p1: read issued this cycle, RAM answers next cycle. The strobe
      // is tagged with the issuer so it survives a grant drop.
      rvld_p1 <= (accept && !wr[owner]) ? oneHot(owner) : 4'b0000;

      if (|(acc & ~gnt)) acc_err <= 1'b1;

      case (state)
        IDLE: begin
          if (|req) begin
            owner    <= winner;
            gnt      <= oneHot(winner);
            burstCnt <= '0;
            state    <= OWN;
          end
        end
        OWN: begin
          burstCnt <= burstCntNext;
          if (relOwn) begin
            gnt   <= '0;
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_mem_arbiter.sv
module tb_img_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req, acc, wr;
  logic [23:0] addr;
  logic [11:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [3:0]  rvalid;
  logic [2:0]  rdata;
  logic        acc_err;
  logic [5:0]  mem_addr;
  logic [2:0]  mem_data;
  logic        mem_wren;
  logic [2:0]  mem_q;

  logic [2:0]  ram [36];
  logic        ramInit;
  int          nCmp = 0;
  int          nBad = 0;

  always #5 clk = ~clk;

  img_mem_arbiter #(.ADDR_SZ(6), .COL_SZ(3), .MAX_BURST(8)) dut (
    .clk(clk), .resetn(resetn), .req(req), .acc(acc), .wr(wr),
    .addr(addr), .wdata(wdata), .gnt(gnt), .owner(owner), .busy(busy),
    .rvalid(rvalid), .rdata(rdata), .acc_err(acc_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q)
  );

  // RAM contents start as (3*i) mod 8: ram[7]=5, ram[9]=3, ram[35]=1.
  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 36; i++) ram[i] <= 3'((3 * i) % 8);
    end else if (mem_wren && mem_addr < 6'd36) begin
      ram[mem_addr] <= mem_data;
    end
    mem_q <= (mem_addr < 6'd36) ? ram[mem_addr] : 3'd0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSlot(input int i, input logic [5:0] a, input logic [2:0] d);
    addr[i*6 +: 6]  = a;
    wdata[i*3 +: 3] = d;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ramInit = 1'b1;
    req = '0; acc = '0; wr = '0; addr = '0; wdata = '0;
    tick(); tick();
    ramInit = 1'b0;
    #1;
    nCmp++; if (gnt !== 4'b0000) begin nBad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    nCmp++; if (owner !== 2'd0) begin nBad++; $display("FAIL reset_owner got %0d want 0", owner); end
    nCmp++; if (busy !== 1'b0) begin nBad++; $display("FAIL reset_busy got %b want 0", busy); end
    nCmp++; if (rvalid !== 4'b0000) begin nBad++; $display("FAIL reset_rvalid got %b want 0000", rvalid); end
    nCmp++; if (acc_err !== 1'b0) begin nBad++; $display("FAIL reset_acc_err got %b want 0", acc_err); end
    nCmp++; if (mem_wren !== 1'b0) begin nBad++; $display("FAIL reset_mem_wren got %b want 0", mem_wren); end
    nCmp++; if (mem_addr !== 6'd0) begin nBad++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
    nCmp++; if (mem_data !== 3'd0) begin nBad++; $display("FAIL reset_mem_data got %0d want 0", mem_data); end
  endtask

  task automatic test_grant_read();
    resetn = 1'b1;
    tick();                       // cycle 1, idle
    req = 4'b0001;                // cycle 2
    tick();                       // cycle 3
    nCmp++; if (gnt !== 4'b0001) begin nBad++; $display("FAIL gr_gnt got %b want 0001", gnt); end
    nCmp++; if (busy !== 1'b1) begin nBad++; $display("FAIL gr_busy got %b want 1", busy); end
    acc = 4'b0001; wr = 4'b0000; setSlot(0, 6'd7, 3'd0);
    #1;
    nCmp++; if (mem_addr !== 6'd7 || mem_wren !== 1'b0) begin nBad++; $display("FAIL gr_memport got addr=%0d wren=%b want addr=7 wren=0", mem_addr, mem_wren); end
    tick();                       // cycle 4
    acc = 4'b0000;
    nCmp++; if (rvalid !== 4'b0001) begin nBad++; $display("FAIL gr_rvalid got %b want 0001", rvalid); end
    nCmp++; if (rdata !== 3'd5) begin nBad++; $display("FAIL gr_rdata got %0d want 5", rdata); end
    req = 4'b0000;
    tick();
    nCmp++; if (gnt !== 4'b0000) begin nBad++; $display("FAIL gr_release got %b want 0000", gnt); end
    tick();
  endtask

  task automatic test_write();
    req = 4'b1000;
    tick();
    nCmp++; if (gnt !== 4'b1000 || owner !== 2'd3) begin nBad++; $display("FAIL wr_grant got gnt=%b owner=%0d want 1000/3", gnt, owner); end
    acc = 4'b1000; wr = 4'b1000; setSlot(3, 6'd35, 3'd0);
    #1;
    nCmp++; if (mem_wren !== 1'b1) begin nBad++; $display("FAIL wr_wren got %b want 1", mem_wren); end
    nCmp++; if (mem_addr !== 6'd35) begin nBad++; $display("FAIL wr_addr got %0d want 35", mem_addr); end
    nCmp++; if (mem_data !== 3'd0) begin nBad++; $display("FAIL wr_data got %0d want 0", mem_data); end
    tick();
    acc = '0; wr = '0; req = '0;
    tick();
    nCmp++; if (gnt !== 4'b0000) begin nBad++; $display("FAIL wr_release got %b want 0000", gnt); end
    req = 4'b0001;
    tick();
    nCmp++; if (gnt !== 4'b0001) begin nBad++; $display("FAIL wr_scan_gnt got %b want 0001", gnt); end
    acc = 4'b0001; setSlot(0, 6'd35, 3'd0);
    tick();
    acc = '0;
    nCmp++; if (rvalid !== 4'b0001 || rdata !== 3'd0) begin nBad++; $display("FAIL wr_readback got rvalid=%b rdata=%0d want 0001/0", rvalid, rdata); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    logic [2:0] rrExp [4];
    rrExp[0] = 3'd0; rrExp[1] = 3'd3; rrExp[2] = 3'd6; rrExp[3] = 3'd1;
    resetn = 1'b0; req = '0;
    tick();
    resetn = 1'b1; req = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      nCmp++; if (gnt !== (4'b0001 << k) || owner !== 2'(k)) begin nBad++; $display("FAIL rr_grant%0d got gnt=%b owner=%0d want %b/%0d", k, gnt, owner, 4'b0001 << k, k); end
      acc = 4'b0001 << k; wr = '0; setSlot(k, 6'(k), 3'd0);
      req[k] = 1'b0;
      tick();
      acc = '0;
      nCmp++; if (gnt !== 4'b0000) begin nBad++; $display("FAIL rr_gap%0d got %b want 0000", k, gnt); end
      nCmp++; if (rvalid !== (4'b0001 << k) || rdata !== rrExp[k]) begin nBad++; $display("FAIL rr_read%0d got rvalid=%b rdata=%0d want %b/%0d", k, rvalid, rdata, 4'b0001 << k, rrExp[k]); end
      tick();
    end
    nCmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin nBad++; $display("FAIL rr_done got gnt=%b busy=%b want 0000/0", gnt, busy); end
  endtask

  task automatic test_burst();
    resetn = 1'b0; req = '0;
    tick();
    resetn = 1'b1; req = 4'b0101;   // cycle 0
    tick();                          // cycle 1
    for (int c = 1; c <= 8; c++) begin
      nCmp++; if (gnt !== 4'b0001) begin nBad++; $display("FAIL burst_own_c%0d got %b want 0001", c, gnt); end
      acc = 4'b0001; wr = '0; setSlot(0, 6'(c), 3'd0);
      tick();
    end
    acc = '0;                        // cycle 9
    nCmp++; if (gnt !== 4'b0000) begin nBad++; $display("FAIL burst_gap got %b want 0000", gnt); end
    tick();                          // cycle 10
    nCmp++; if (gnt !== 4'b0100 || owner !== 2'd2) begin nBad++; $display("FAIL burst_handoff got gnt=%b owner=%0d want 0100/2", gnt, owner); end
    for (int c = 0; c < 3; c++) begin
      tick();
      nCmp++; if (gnt !== 4'b0100) begin nBad++; $display("FAIL burst_hold%0d got %b want 0100", c, gnt); end
    end
    req = 4'b0001;
    tick();
    nCmp++; if (gnt !== 4'b0000) begin nBad++; $display("FAIL burst_rel2 got %b want 0000", gnt); end
    tick();
    nCmp++; if (gnt !== 4'b0001) begin nBad++; $display("FAIL burst_back0 got %b want 0001", gnt); end
    acc = 4'b0001;
    for (int c = 0; c < 10; c++) tick();
    acc = '0;
    nCmp++; if (gnt !== 4'b0001) begin nBad++; $display("FAIL burst_nocomp got %b want 0001", gnt); end
    req = '0;
    tick(); tick();
  endtask

  task automatic test_violation();
    resetn = 1'b0;
    tick();
    resetn = 1'b1; req = 4'b0001;
    tick();
    nCmp++; if (gnt !== 4'b0001 || acc_err !== 1'b0) begin nBad++; $display("FAIL viol_pre got gnt=%b acc_err=%b want 0001/0", gnt, acc_err); end
    acc = 4'b0010; wr = 4'b0010; setSlot(1, 6'd9, 3'd7);
    #1;
    nCmp++; if (mem_wren !== 1'b0 || mem_addr !== 6'd0) begin nBad++; $display("FAIL viol_port got wren=%b addr=%0d want 0/0", mem_wren, mem_addr); end
    tick();
    acc = '0; wr = '0;
    nCmp++; if (acc_err !== 1'b1) begin nBad++; $display("FAIL viol_set got %b want 1", acc_err); end
    tick(); tick(); tick();
    nCmp++; if (acc_err !== 1'b1) begin nBad++; $display("FAIL viol_sticky got %b want 1", acc_err); end
    nCmp++; if (ram[9] !== 3'd3) begin nBad++; $display("FAIL viol_ram9 got %0d want 3", ram[9]); end
  endtask

  task automatic test_reset_mid();
    req = 4'b0010;
    tick();
    nCmp++; if (gnt !== 4'b0000) begin nBad++; $display("FAIL rm_rel0 got %b want 0000", gnt); end
    tick();
    nCmp++; if (gnt !== 4'b0010 || owner !== 2'd1) begin nBad++; $display("FAIL rm_own1 got gnt=%b owner=%0d want 0010/1", gnt, owner); end
    acc = 4'b0010; wr = '0; setSlot(1, 6'd3, 3'd0);
    resetn = 1'b0;
    tick();
    acc = '0;
    nCmp++; if (gnt !== 4'b0000 || busy !== 1'b0) begin nBad++; $display("FAIL rm_gnt got gnt=%b busy=%b want 0000/0", gnt, busy); end
    nCmp++; if (rvalid !== 4'b0000) begin nBad++; $display("FAIL rm_rvalid got %b want 0000", rvalid); end
    nCmp++; if (acc_err !== 1'b0) begin nBad++; $display("FAIL rm_acc_err got %b want 0", acc_err); end
    nCmp++; if (owner !== 2'd0) begin nBad++; $display("FAIL rm_owner got %0d want 0", owner); end
    resetn = 1'b1; req = 4'b0110;
    tick();
    nCmp++; if (gnt !== 4'b0010 || owner !== 2'd1) begin nBad++; $display("FAIL rm_regrant got gnt=%b owner=%0d want 0010/1", gnt, owner); end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_grant_read();
    test_write();
    test_round_robin();
    test_burst();
    test_violation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
